// File: rtl/data_sync_pkg.sv
// Shared types and limits for the req/ack CDC receiver (data_sync_rx).
package data_sync_pkg;

  // Receiver handshake states: waiting for a request, or holding the acknowledge.
  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } rx_state_t;

  // A single flop cannot resolve metastability, so the request chain needs at least two.
  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/req_bit_sync.sv
// Single-bit synchronizer: NUM_STAGES flops in series with an asynchronous
// active-low clear. The input feeds the first flop with no logic in front of it.
module req_bit_sync #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic Async_Reset,
  input  logic d,
  output logic q
);

  logic [NUM_STAGES-1:0] sync_p;

  // Shift the asynchronous level through the chain; the oldest bit is the synchronized output.
  always_ff @(posedge CLK or negedge Async_Reset) begin
    if (!Async_Reset) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[NUM_STAGES-2:0], d};
    end
  end

  assign q = sync_p[NUM_STAGES-1];

endmodule

// File: rtl/data_sync_rx.sv
// Destination-side responder of a 4-phase req/ack clock-domain crossing.
// Synchronizes Req_in, captures the quasi-static Unsync_bus once per handshake,
// strobes enable_pulse for one cycle and returns a registered Ack_out level.
// Optional feature: define DATA_SYNC_PARITY_EN to add Unsync_par / Par_err and
// reject captures whose even parity is wrong (Ack_out still rises).
module data_sync_rx
  import data_sync_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int BUS_WIDTH  = 8
) (
  input  logic                 CLK,
  input  logic                 Async_Reset,
  input  logic [BUS_WIDTH-1:0] Unsync_bus,
`ifdef DATA_SYNC_PARITY_EN
  input  logic                 Unsync_par,
  output logic                 Par_err,
`endif
  input  logic                 Req_in,
  output logic                 Ack_out,
  output logic [BUS_WIDTH-1:0] sync_bus,
  output logic                 enable_pulse,
  output logic                 Busy
);

  if (NUM_STAGES < MIN_SYNC_STAGES) begin : g_bad_stages
    $error("data_sync_rx: NUM_STAGES must be at least %0d", MIN_SYNC_STAGES);
  end

  rx_state_t state_q, state_d;
  logic      req_s;
  logic      capture;
  logic      capture_ok;

`ifdef DATA_SYNC_PARITY_EN
  // Even parity across data and parity bit: the XOR of all bits must be zero.
  function automatic logic parity_ok(input logic [BUS_WIDTH-1:0] data, input logic par);
    return ~^{data, par};
  endfunction

  assign capture_ok = capture & parity_ok(Unsync_bus, Unsync_par);
`else
  assign capture_ok = capture;
`endif

  // ---- stage 0: only the request level crosses; the bus is sampled directly at capture
  req_bit_sync #(
    .NUM_STAGES (NUM_STAGES)
  ) u_req_sync (
    .CLK         (CLK),
    .Async_Reset (Async_Reset),
    .d           (Req_in),
    .q           (req_s)
  );

  // ---- stage 1: handshake FSM and capture register
  // Next-state logic: accept a request from IDLE, release the acknowledge once req_s drops.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = ACK;
          capture = 1'b1;
        end
      end
      ACK: begin
        if (!req_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register and handshake outputs; Ack_out mirrors the state being entered.
  always_ff @(posedge CLK or negedge Async_Reset) begin
    if (!Async_Reset) begin
      state_q      <= IDLE;
      Ack_out      <= 1'b0;
      enable_pulse <= 1'b0;
    end else begin
      state_q      <= state_d;
      Ack_out      <= (state_d == ACK);
      enable_pulse <= capture_ok;
    end
  end

  // Capture register: loads only on an accepted transfer, otherwise holds.
  always_ff @(posedge CLK or negedge Async_Reset) begin
    if (!Async_Reset) begin
      sync_bus <= '0;
    end else if (capture_ok) begin
      sync_bus <= Unsync_bus;
    end
  end

`ifdef DATA_SYNC_PARITY_EN
  // One-cycle parity error flag for a capture that was rejected.
  always_ff @(posedge CLK or negedge Async_Reset) begin
    if (!Async_Reset) begin
      Par_err <= 1'b0;
    end else begin
      Par_err <= capture & ~capture_ok;
    end
  end
`endif

  assign Busy = (state_q != IDLE);

endmodule

// File: tb/tb_data_sync_rx.sv
// Directed bench for data_sync_rx: one instance with NUM_STAGES=2, one with
// NUM_STAGES=3. Inputs change at posedge+1; outputs are sampled there too.
// Parity checks are compiled in when DATA_SYNC_PARITY_EN is defined.
module tb_data_sync_rx;

  logic       CLK = 1'b0;
  logic       Async_Reset;
  logic [7:0] bus;
  logic       req2, req3;
  logic       ack2, ack3, pulse2, pulse3, busy2, busy3;
  logic [7:0] sbus2, sbus3;
  int         n_checks = 0;
  int         n_errors = 0;
  int         npulse;
  logic [7:0] last2;

`ifdef DATA_SYNC_PARITY_EN
  logic par_ovr_en = 1'b0;
  logic par_val    = 1'b0;
  logic par;
  logic perr2, perr3;
  assign par = par_ovr_en ? par_val : ^bus;
`endif

  always #5 CLK = ~CLK;

  data_sync_rx #(.NUM_STAGES(2), .BUS_WIDTH(8)) u_dut2 (
    .CLK          (CLK),
    .Async_Reset  (Async_Reset),
    .Unsync_bus   (bus),
`ifdef DATA_SYNC_PARITY_EN
    .Unsync_par   (par),
    .Par_err      (perr2),
`endif
    .Req_in       (req2),
    .Ack_out      (ack2),
    .sync_bus     (sbus2),
    .enable_pulse (pulse2),
    .Busy         (busy2)
  );

  data_sync_rx #(.NUM_STAGES(3), .BUS_WIDTH(8)) u_dut3 (
    .CLK          (CLK),
    .Async_Reset  (Async_Reset),
    .Unsync_bus   (bus),
`ifdef DATA_SYNC_PARITY_EN
    .Unsync_par   (par),
    .Par_err      (perr3),
`endif
    .Req_in       (req3),
    .Ack_out      (ack3),
    .sync_bus     (sbus3),
    .enable_pulse (pulse3),
    .Busy         (busy3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    @(posedge CLK);
    #1;
  endtask

  // Full request phase on the NUM_STAGES=2 instance; pulse expected 2 edges after sampling edge.
  task automatic xfer2(input logic [7:0] data, input string tag);
    bus  = data;
    req2 = 1'b1;
    edge1();  // sampling edge
    check({tag, "_e0_pulse"}, pulse2, 1'b0);
    edge1();
    check({tag, "_e1_pulse"}, pulse2, 1'b0);
    check({tag, "_e1_ack"}, ack2, 1'b0);
    edge1();
    check({tag, "_e2_pulse"}, pulse2, 1'b1);
    check({tag, "_e2_bus"}, sbus2, data);
    check({tag, "_e2_ack"}, ack2, 1'b1);
    check({tag, "_e2_busy"}, busy2, 1'b1);
    edge1();
    check({tag, "_e3_pulse"}, pulse2, 1'b0);
    check({tag, "_e3_ack"}, ack2, 1'b1);
    last2 = data;
  endtask

  // Release phase on the NUM_STAGES=2 instance; Ack_out falls 2 edges after sampling edge.
  task automatic drop2(input string tag);
    req2 = 1'b0;
    edge1();
    edge1();
    check({tag, "_d1_ack"}, ack2, 1'b1);
    edge1();
    check({tag, "_d2_ack"}, ack2, 1'b0);
    check({tag, "_d2_busy"}, busy2, 1'b0);
    check({tag, "_d2_pulse"}, pulse2, 1'b0);
  endtask

  initial begin
    Async_Reset = 1'b0;
    bus  = 8'h00;
    req2 = 1'b0;
    req3 = 1'b0;
    last2 = 8'h00;
    repeat (3) edge1();
    check("rst_ack2", ack2, 1'b0);
    check("rst_bus2", sbus2, 8'h00);
    check("rst_pulse2", pulse2, 1'b0);
    check("rst_busy2", busy2, 1'b0);
    check("rst_ack3", ack3, 1'b0);
    check("rst_busy3", busy3, 1'b0);
    Async_Reset = 1'b1;
    edge1();

    // 1: basic transfer
    xfer2(8'hA5, "t1");
    // 2: release, then second transfer
    drop2("t2a");
    xfer2(8'h3C, "t2b");

    // 3: hold request 50 cycles while the bus moves; no further pulses
    npulse = 0;
    for (int i = 0; i < 50; i++) begin
      bus = 8'(i * 7 + 1);
      edge1();
      if (pulse2) npulse++;
    end
    check("t3_npulse", npulse, 0);
    check("t3_bus", sbus2, 8'h3C);
    check("t3_ack", ack2, 1'b1);

    // 4: asynchronous reset while in ACK with request still high
    #2;
    Async_Reset = 1'b0;
    #1;
    check("t4_ack", ack2, 1'b0);
    check("t4_bus", sbus2, 8'h00);
    check("t4_pulse", pulse2, 1'b0);
    check("t4_busy", busy2, 1'b0);
    bus = 8'h5A;
    edge1();
    #2;
    Async_Reset = 1'b1;
    edge1();  // sampling edge
    check("t4_e0_pulse", pulse2, 1'b0);
    edge1();
    check("t4_e1_pulse", pulse2, 1'b0);
    edge1();
    check("t4_e2_pulse", pulse2, 1'b1);
    check("t4_e2_bus", sbus2, 8'h5A);
    check("t4_e2_ack", ack2, 1'b1);
    last2 = 8'h5A;
    drop2("t4d");

    // 5: sub-period glitch between edges on the NUM_STAGES=3 instance
    #2;
    req3 = 1'b1;
    #4;
    req3 = 1'b0;
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      edge1();
      if (pulse3 || ack3) npulse++;
    end
    check("t5_glitch", npulse, 0);
    check("t5_bus3", sbus3, 8'h00);

    // NUM_STAGES=3 latency: pulse 3 edges after the sampling edge
    bus  = 8'hC3;
    req3 = 1'b1;
    edge1();
    edge1();
    edge1();
    check("t5_e2_pulse3", pulse3, 1'b0);
    edge1();
    check("t5_e3_pulse3", pulse3, 1'b1);
    check("t5_e3_bus3", sbus3, 8'hC3);
    check("t5_e3_ack3", ack3, 1'b1);
    req3 = 1'b0;
    repeat (5) edge1();
    check("t5_idle3", busy3, 1'b0);

`ifdef DATA_SYNC_PARITY_EN
    // 6: bad parity rejected, then good parity accepted
    par_ovr_en = 1'b1;
    par_val    = 1'b0;
    bus  = 8'h01;
    req2 = 1'b1;
    edge1();
    edge1();
    check("t6_e1_perr", perr2, 1'b0);
    edge1();
    check("t6_e2_perr", perr2, 1'b1);
    check("t6_e2_pulse", pulse2, 1'b0);
    check("t6_e2_bus", sbus2, last2);
    check("t6_e2_ack", ack2, 1'b1);
    edge1();
    check("t6_e3_perr", perr2, 1'b0);
    drop2("t6d");
    par_val = 1'b1;
    xfer2(8'h01, "t6g");
    check("t6g_perr", perr2, 1'b0);
    drop2("t6gd");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
